uart_frame_parser: RTL

Downstream consumer of the UART receiver's byte stream. It hunts for a sync byte, then parses a command frame: SYNC, CMD, LEN, LEN payload bytes, CHK. It streams payload bytes out as they arrive and reports per-frame pass/fail with an error code. It has no backpressure because the UART source cannot stall. All outputs are registered.

---
 rtl/uart_frame_parser.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/uart_frame_parser.sv
// Parses SYNC/CMD/LEN/payload/CHK command frames from a UART byte stream.
// Payload streams out speculatively; each frame ends with one pass/fail report.
module uart_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_byte_valid,
  input  logic       i_rx_err,
  output logic [7:0] o_cmd,
  output logic [7:0] o_len,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  output logic       o_data_last,
  output logic       o_frame_done,
  output logic       o_frame_ok,
  output logic [2:0] o_err_code
);

  localparam int unsigned    TmoW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     MaxLen  = 8'(MAX_LEN);

  localparam logic [2:0] ErrNone    = 3'd0;
  localparam logic [2:0] ErrParity  = 3'd1;
  localparam logic [2:0] ErrLength  = 3'd2;
  localparam logic [2:0] ErrChksum  = 3'd3;
  localparam logic [2:0] ErrTimeout = 3'd4;

  typedef enum logic [2:0] {
    StHunt,
    StCmd,
    StLen,
    StPay,
    StChk
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic [7:0] cmd_d, len_d, data_d;
  logic       data_valid_d, data_last_d, done_d, ok_d;
  logic [2:0] err_d;

  logic       ev_any, ev_byte, expired, abort;
  logic [2:0] abort_code;
  logic [7:0] sum_next;

  always_comb begin
    // A simultaneous parity error overrides the byte strobe.
    ev_any   = i_rx_byte_valid | i_rx_err;
    ev_byte  = i_rx_byte_valid & ~i_rx_err;
    sum_next = sum_q + i_rx_byte;

    state_d      = state_q;
    sum_d        = sum_q;
    cnt_d        = cnt_q;
    tmo_d        = ev_any ? '0 : tmo_q + TmoW'(1);
    cmd_d        = o_cmd;
    len_d        = o_len;
    data_d       = o_data;
    data_valid_d = 1'b0;
    data_last_d  = 1'b0;
    done_d       = 1'b0;
    ok_d         = o_frame_ok;
    err_d        = o_err_code;
    abort        = 1'b0;
    abort_code   = ErrNone;
    expired      = !ev_any && (tmo_q == TmoLast);

    case (state_q)
      StHunt: begin
        if (ev_byte && (i_rx_byte == SYNC_BYTE)) state_d = StCmd;
      end
      StCmd: begin
        if (ev_byte) begin
          cmd_d   = i_rx_byte;
          sum_d   = i_rx_byte;
          state_d = StLen;
        end
      end
      StLen: begin
        if (ev_byte) begin
          if (i_rx_byte > MaxLen) begin
            abort      = 1'b1;
            abort_code = ErrLength;
          end else begin
            len_d   = i_rx_byte;
            sum_d   = sum_next;
            cnt_d   = '0;
            state_d = (i_rx_byte == 8'd0) ? StChk : StPay;
          end
        end
      end
      StPay: begin
        if (ev_byte) begin
          data_d       = i_rx_byte;
          data_valid_d = 1'b1;
          sum_d        = sum_next;
          cnt_d        = cnt_q + 8'd1;
          if ((cnt_q + 8'd1) == o_len) begin
            data_last_d = 1'b1;
            state_d     = StChk;
          end
        end
      end
      StChk: begin
        if (ev_byte) begin
          if (sum_next == 8'd0) begin
            done_d  = 1'b1;
            ok_d    = 1'b1;
            err_d   = ErrNone;
            state_d = StHunt;
          end else begin
            abort      = 1'b1;
            abort_code = ErrChksum;
          end
        end
      end
      default: state_d = StHunt;
    endcase

    if (state_q inside {StCmd, StLen, StPay, StChk}) begin
      if (i_rx_err) begin
        abort      = 1'b1;
        abort_code = ErrParity;
      end else if (expired) begin
        abort      = 1'b1;
        abort_code = ErrTimeout;
      end
    end

    if (abort) begin
      done_d  = 1'b1;
      ok_d    = 1'b0;
      err_d   = abort_code;
      state_d = StHunt;
    end

    // Timeout only runs inside a frame.
    if (state_d == StHunt) tmo_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= StHunt;
      sum_q        <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      o_cmd        <= '0;
      o_len        <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_data_last  <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_ok   <= 1'b0;
      o_err_code   <= '0;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      o_cmd        <= cmd_d;
      o_len        <= len_d;
      o_data       <= data_d;
      o_data_valid <= data_valid_d;
      o_data_last  <= data_last_d;
      o_frame_done <= done_d;
      o_frame_ok   <= ok_d;
      o_err_code   <= err_d;
    end
  end

endmodule
